// File: rtl/mem_access_unit.sv
// Wait-stated single-word memory responder for the multicycle datapath.
// Optional MEM_RANGE_CHECK_EN: flag and suppress accesses whose Addr bits above DEPTH_LOG2 are nonzero.
module mem_access_unit #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MRead,
  input  logic        MWrite,
  input  logic [15:0] Addr,
  input  logic [15:0] MDataIn,
  output logic [15:0] MDataOut,
  output logic        MReady,
  output logic        Busy,
  output logic        MErr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  range_err;
  logic                  mem_we;
  logic [15:0]           mem [2**DEPTH_LOG2];

`ifdef MEM_RANGE_CHECK_EN
  assign range_err = |Addr[15:DEPTH_LOG2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[15:DEPTH_LOG2];
  assign range_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MRead || MWrite) begin
          addr_d  = Addr[DEPTH_LOG2-1:0];
          wdata_d = MDataIn;
          wr_d    = MWrite;
          err_d   = range_err;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // Out-of-range requests still take full timing but never touch the array.
          if (wr_q) mem_we = !err_q;
          else      rdata_d = err_q ? '1 : mem[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; reset only cancels the pending write via state_q.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign MDataOut = rdata_q;
  assign MReady   = (state_q == DONE);
  assign Busy     = (state_q != IDLE);
  assign MErr     = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 2-wait-state and a zero-wait instance against a word-array reference model.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        mr0 = 1'b0, mw0 = 1'b0, mr1 = 1'b0, mw1 = 1'b0;
  logic [15:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
  logic [15:0] dout0, dout1;
  logic        rdy0, rdy1, bsy0, bsy1, err0, err1;

  int checks = 0;
  int failures = 0;

  logic [15:0] ref_mem [2][1024];
  bit          ref_val [2][1024];
  logic [15:0] last_rd [2];
  bit          last_ok [2];

  mem_access_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u0 (
    .CLK(CLK), .Reset(Reset), .MRead(mr0), .MWrite(mw0), .Addr(a0), .MDataIn(d0),
    .MDataOut(dout0), .MReady(rdy0), .Busy(bsy0), .MErr(err0)
  );

  mem_access_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u1 (
    .CLK(CLK), .Reset(Reset), .MRead(mr1), .MWrite(mw1), .Addr(a1), .MDataIn(d1),
    .MDataOut(dout1), .MReady(rdy1), .Busy(bsy1), .MErr(err1)
  );

  always #5 CLK = ~CLK;

  function automatic int unsigned wc(input int unsigned i);
    return (i == 0) ? 2 : 0;
  endfunction
  function automatic logic [15:0] dout(input int unsigned i);
    return (i == 0) ? dout0 : dout1;
  endfunction
  function automatic logic rdy(input int unsigned i);
    return (i == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic bsy(input int unsigned i);
    return (i == 0) ? bsy0 : bsy1;
  endfunction
  function automatic logic merr(input int unsigned i);
    return (i == 0) ? err0 : err1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int unsigned i, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    if (i == 0) begin mr0 = rd; mw0 = wr; a0 = a; d0 = d; end
    else        begin mr1 = rd; mw1 = wr; a1 = a; d1 = d; end
  endtask

  // One complete request starting and ending at a falling edge.
  task automatic req(input int unsigned i, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d);
    logic        oob;
    logic [9:0]  idx;
    int unsigned cyc;
    idx = a[9:0];
`ifdef MEM_RANGE_CHECK_EN
    oob = (a[15:10] != 6'd0);
`else
    oob = 1'b0;
`endif
    if (wr) begin
      if (!oob) begin ref_mem[i][idx] = d; ref_val[i][idx] = 1'b1; end
    end else if (oob) begin
      last_rd[i] = 16'hFFFF; last_ok[i] = 1'b1;
    end else begin
      last_rd[i] = ref_mem[i][idx]; last_ok[i] = ref_val[i][idx];
    end
    drive(i, rd, wr, a, d);
    @(posedge CLK);
    @(negedge CLK);
    chk("busy_after_capture", 16'(bsy(i)), 16'd1);
    chk("ready_after_capture", 16'(rdy(i)), 16'd0);
    drive(i, rd, wr, 16'($urandom), 16'($urandom));
    cyc = 0;
    while (rdy(i) !== 1'b1 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    chk("latency", 16'(cyc), 16'(wc(i) + 1));
    if (last_ok[i]) chk("mdataout", dout(i), last_rd[i]);
    chk("merr", 16'(merr(i)), 16'(oob));
    chk("busy_in_done", 16'(bsy(i)), 16'd1);
    drive(i, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    chk("ready_pulse_end", 16'(rdy(i)), 16'd0);
    chk("busy_end", 16'(bsy(i)), 16'd0);
  endtask

  initial begin
    logic [15:0] ra;
    last_rd[0] = '0; last_rd[1] = '0;
    last_ok[0] = 1'b1; last_ok[1] = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #2 Reset = 1'b1;
    #1;
    chk("rst_dout0", dout0, 16'h0000);
    chk("rst_ready0", 16'(rdy0), 16'd0);
    chk("rst_busy0", 16'(bsy0), 16'd0);
    chk("rst_merr0", 16'(err0), 16'd0);
    chk("rst_dout1", dout1, 16'h0000);
    chk("rst_busy1", 16'(bsy1), 16'd0);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);

    // Write then read back with two wait states.
    req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);

    // Both strobes plus upper-bit aliasing.
    req(0, 1'b0, 1'b1, 16'h0005, 16'h7777);
    req(0, 1'b1, 1'b1, 16'h0405, 16'h00A5);
    req(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    req(0, 1'b1, 1'b0, 16'h0405, 16'h0000);

    // Zero wait states, strobe held through DONE.
    req(1, 1'b0, 1'b1, 16'h0003, 16'h1234);
    drive(1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    @(posedge CLK);
    @(negedge CLK);
    chk("zw_busy", 16'(bsy1), 16'd1);
    chk("zw_ready_early", 16'(rdy1), 16'd0);
    @(negedge CLK);
    chk("zw_ready", 16'(rdy1), 16'd1);
    chk("zw_dout", dout1, 16'h1234);
    @(negedge CLK);
    chk("zw_idle_gap_busy", 16'(bsy1), 16'd0);
    chk("zw_idle_gap_ready", 16'(rdy1), 16'd0);
    @(negedge CLK);
    chk("zw_recapture_busy", 16'(bsy1), 16'd1);
    chk("zw_recapture_ready", 16'(rdy1), 16'd0);
    @(negedge CLK);
    chk("zw_second_ready", 16'(rdy1), 16'd1);
    chk("zw_second_dout", dout1, 16'h1234);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    chk("zw_end_busy", 16'(bsy1), 16'd0);
    last_rd[1] = 16'h1234; last_ok[1] = 1'b1;

    // Reset during WAIT discards the write.
    req(0, 1'b0, 1'b1, 16'h0020, 16'h1111);
    drive(0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    @(posedge CLK);
    @(negedge CLK);
    chk("rw_busy", 16'(bsy0), 16'd1);
    #2 Reset = 1'b1;
    #1;
    chk("rw_busy_rst", 16'(bsy0), 16'd0);
    chk("rw_ready_rst", 16'(rdy0), 16'd0);
    chk("rw_dout_rst", dout0, 16'h0000);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    Reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    last_ok[0] = 1'b1; last_ok[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("rw_no_ready", 16'(rdy0), 16'd0);
    end
    req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);

    // Preload a small window in both instances, then random traffic.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++)
        req(i, 1'b0, 1'b1, 16'(k), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      int unsigned inst, kind;
      inst = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      ra = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra[15:10] = 6'($urandom_range(1, 63));
      req(inst, kind != 2, kind >= 2, ra, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
